prog_loader: RTL

Instruction-memory program loader for the 16-bit processor. It accepts a program as a stream of bytes over a valid/ready handshake and assembles byte pairs into 16-bit instruction words. It writes those words into the processor's 128-entry instruction memory, starting at address 0, and holds the processor in reset while loading. It is the write side of the instruction memory that the control unit's PC reads.

---
 rtl/prog_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: streams a program in as bytes (high byte first), packs byte
// pairs into 16-bit words and writes them to instruction memory from address
// 0 upward, holding the processor in reset for the duration of the load.
module prog_loader #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128,
    parameter int WORD_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        Word_Count,
    input  logic [7:0]        In_Byte,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic              IM_Wr,
    output logic [ADDR_W-1:0] IM_Addr,
    output logic [WORD_W-1:0] IM_Data,
    output logic              Cpu_Hold,
    output logic              Busy,
    output logic              Done,
    output logic [15:0]       Checksum,
    output logic [2:0]        State
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [7:0]          hi_q, hi_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [15:0]         sum_q, sum_d;
    logic                last_word;

    assign last_word = ({1'b0, cnt_q} == (n_q - CNT_W'(1)));

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (Word_Count == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        if (int'(Word_Count) > DEPTH) n_d = CNT_W'(DEPTH);
                        else                          n_d = CNT_W'(Word_Count);
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (In_Valid) begin
                    hi_d    = In_Byte;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                // Write port registers load on entry to WRITE so they stay
                // stable through it and hold their value afterwards.
                if (In_Valid) begin
                    addr_d  = cnt_q;
                    data_d  = WORD_W'({hi_q, In_Byte});
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                sum_d = sum_q + 16'(data_q);
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = S_HI;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        In_Ready = (state_q == S_HI) || (state_q == S_LO);
        IM_Wr    = (state_q == S_WRITE);
        Done     = (state_q == S_DONE);
        Busy     = (state_q != S_IDLE);
        Cpu_Hold = Busy;
        IM_Addr  = addr_q;
        IM_Data  = data_q;
        Checksum = sum_q;
        State    = state_q;
    end

endmodule
